shift_add_multiplier: RTL and testbench

//  Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.

---
 rtl/shift_add_multiplier_pkg.sv | 33 +++
 rtl/shift_add_multiplier_step.sv | 26 ++
 rtl/shift_add_multiplier.sv | 129 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier: widths, op and FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package shift_add_multiplier_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  // RV32M multiply group, encoded as on the issue bus
  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } mul_state_e;

  // rs1 is treated as signed for every op except MULHU
  function automatic logic op_rs1_signed(input logic [1:0] op);
    return (op != MUL_OP_MULHU);
  endfunction

  // rs2 is treated as signed only for MUL and MULH
  function automatic logic op_rs2_signed(input logic [1:0] op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_step.sv
// One radix-2 add-shift step: conditionally add a into the upper half, then shift {acc,b} right.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the step result is registered.
module shift_add_multiplier_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_a,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_b
);

  logic [XLEN:0] w_sum;

  // Add multiplicand when the current multiplier LSB is set; the carry becomes the new acc MSB
  always_comb begin
    w_sum = {1'b0, i_acc};
    if (i_b[0]) begin
      w_sum = w_sum + {1'b0, i_a};
    end
    o_acc = w_sum[XLEN:1];
    o_b   = {w_sum[0], i_b[XLEN-1:1]};
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative RV32M multiplier: sign-strip operands, XLEN add-shift steps, then re-sign and pick half.
// Latency: start at edge E0 -> done pulse after edge E0+XLEN+1.
// Backpressure: start is ignored while busy (no queuing); flush aborts without producing done.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  mul_state_e        r_state;
  logic [1:0]        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_a_mag;
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_b;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_rs1_neg;
  logic              w_rs2_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_acc_nxt;
  logic [XLEN-1:0]   w_b_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_sgn;
  logic [XLEN-1:0]   w_res;

  // Operand magnitudes and product sign; |most-negative| still fits as an unsigned XLEN value
  always_comb begin
    w_rs1_neg = op_rs1_signed(op) & rs1[XLEN-1];
    w_rs2_neg = op_rs2_signed(op) & rs2[XLEN-1];
    w_a_mag   = w_rs1_neg ? -rs1 : rs1;
    w_b_mag   = w_rs2_neg ? -rs2 : rs2;
  end

  shift_add_multiplier_step #(
    .XLEN (XLEN)
  ) u_step (
    .i_acc (r_acc),
    .i_b   (r_b),
    .i_a   (r_a_mag),
    .o_acc (w_acc_nxt),
    .o_b   (w_b_nxt)
  );

  // Re-apply the sign to the full-width product and select the half the op asks for
  always_comb begin
    w_prod     = {r_acc, r_b};
    w_prod_sgn = r_neg ? -w_prod : w_prod;
    w_res      = (r_op == MUL_OP_MUL) ? w_prod_sgn[XLEN-1:0] : w_prod_sgn[2*XLEN-1:XLEN];
  end

  // Control FSM and datapath registers; flush overrides everything except reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_op     <= 2'b00;
      r_neg    <= 1'b0;
      r_a_mag  <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_op    <= op;
              r_neg   <= w_rs1_neg ^ w_rs2_neg;
              r_a_mag <= w_a_mag;
              r_b     <= w_b_mag;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= ST_CALC;
            end
          end
          ST_CALC: begin
            r_acc <= w_acc_nxt;
            r_b   <= w_b_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_CNT) begin
              r_state <= ST_FINISH;
            end
          end
          ST_FINISH: begin
            r_result <= w_res;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier with a result/latency scoreboard fed at start time.
// Latency: expects done 33 edges after the accepting edge.
// Backpressure: exercises start-while-busy, back-to-back start, flush and mid-op reset.
module tb_shift_add_multiplier;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;
  localparam int         LAT       = 33;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] rs1   = '0;
  logic [31:0] rs2   = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb_res[$];
  int          sb_cyc[$];
  logic [31:0] m_exp;
  int          m_cyc;

  shift_add_multiplier dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done must match the oldest pending op in value and cycle
  always @(negedge clk) begin
    if (rstn && done) begin
      chk("done_expected", 32'(sb_res.size() != 0), 32'd1);
      if (sb_res.size() != 0) begin
        m_exp = sb_res.pop_front();
        m_cyc = sb_cyc.pop_front();
        chk("result", result, m_exp);
        chk("latency_edge", cyc, m_cyc);
      end
    end
  end

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((busy || sb_res.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(busy || sb_res.size() != 0), 32'd0);
  endtask

  // Issue one op from IDLE, push its expectation, scramble inputs, and drain
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    sb_res.push_back(exp);
    sb_cyc.push_back(cyc + LAT);
    start = 1'b0;
    op    = ~o;
    rs1   = $urandom;
    rs2   = $urandom;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_idle(60, {tag, "_drain"});
  endtask

  initial begin
    // Reset state
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Signed, unsigned and mixed patterns including most-negative operands
    do_op(OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3");
    do_op(OP_MULH,   32'h80000000,   32'h80000000, 32'h40000000, "mulh_min");
    do_op(OP_MUL,    32'h80000000,   32'h80000000, 32'h00000000, "mul_min");
    do_op(OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_ones");
    do_op(OP_MULH,   32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, "mulh_m1_2");
    do_op(OP_MULHSU, 32'h80000000,   32'd2,        32'hFFFFFFFF, "mulhsu_min_2");
    do_op(OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ones");

    // Flush and start in the same IDLE cycle: flush wins
    op = OP_MUL; rs1 = 32'd1; rs2 = 32'd1; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_beats_start", 32'(busy), 32'd0);

    // Flush on the 10th CALC cycle: op dies silently, result unchanged
    op = OP_MUL; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("flush_pre_busy", 32'(busy), 32'd1);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_result_held", result, 32'hFFFFFFFE);
    do_op(OP_MUL, 32'd3, 32'd5, 32'h0000000F, "mul_after_flush");

    // start held high 40 edges: accepted at E0 and again in the done cycle only
    op = OP_MUL; rs1 = 32'd6; rs2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    sb_res.push_back(32'd42); sb_cyc.push_back(cyc + LAT);
    sb_res.push_back(32'd42); sb_cyc.push_back(cyc + LAT + 1 + LAT);
    repeat (39) @(posedge clk);
    #1;
    start = 1'b0;
    chk("held_second_busy", 32'(busy), 32'd1);
    wait_idle(80, "held_drain");

    // Reset pulse mid-CALC: everything cleared, no done for the lost op
    op = OP_MULH; rs1 = 32'd123; rs2 = 32'd456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    rstn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_idle", 32'(busy), 32'd0);
    do_op(OP_MULHU, 32'h0, 32'hFFFFFFFF, 32'h0, "mulhu_zero");

    chk("sb_empty", 32'(sb_res.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
